serial_add_sequencer: RTL and testbench

- Upstream command sequencer for the 32-bit serial adder.
- Accepts operand pairs over a valid/ready stream and buffers them in a small FIFO.
- Issues each pair to the adder with a one-cycle start pulse, waits for done, and captures sum/carry.
- Returns each result, in order, on a valid/ready result stream. The adder sees exactly one operation in flight at a time.

---
 rtl/serial_add_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_serial_add_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sequencer.sv
// Command sequencer for the serial adder: buffers operand pairs, issues them one at a time, returns results in order.
// Optional watchdog on the adder's done is enabled by defining SERIAL_SEQ_TIMEOUT_EN.
module serial_add_sequencer #(
  parameter int WIDTH          = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_a,
  input  logic [WIDTH-1:0]            in_b,
  output logic                        adder_start,
  output logic [WIDTH-1:0]            adder_a,
  output logic [WIDTH-1:0]            adder_b,
  input  logic [WIDTH-1:0]            adder_sum,
  input  logic                        adder_carry,
  input  logic                        adder_done,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_sum,
  output logic                        out_carry,
  output logic                        out_err,
  output logic [$clog2(FIFO_DEPTH):0] pending,
  output logic                        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("serial_add_sequencer: illegal FIFO_DEPTH or TIMEOUT_CYCLES");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_DONE,
    S_RESULT,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] fifo_a_q [FIFO_DEPTH];
  logic [WIDTH-1:0] fifo_b_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  logic [WIDTH-1:0] adder_a_q, adder_b_q;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_carry_q, out_carry_d;

  logic do_push, do_pop;

  assign in_ready = (count_q != CW'(FIFO_DEPTH));
  assign do_push  = in_valid && in_ready;
  // A stale done from the previous op must fall before the next issue.
  assign do_pop   = (state_q == S_IDLE) && (count_q != '0) && !adder_done;

  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_a_q[wr_ptr_q] <= in_a;
      fifo_b_q[wr_ptr_q] <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      adder_a_q <= '0;
      adder_b_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
        adder_a_q <= fifo_a_q[rd_ptr_q];
        adder_b_q <= fifo_b_q[rd_ptr_q];
      end
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (!do_push && do_pop) count_q <= count_q - CW'(1);
    end
  end

`ifdef SERIAL_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_q, timer_d;
  logic          out_err_q, out_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_carry_d = out_carry_q;
`ifdef SERIAL_SEQ_TIMEOUT_EN
    timer_d     = timer_q;
    out_err_d   = out_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (do_pop) state_d = S_START;
      end
      S_START: begin
        state_d = S_WAIT_DONE;
`ifdef SERIAL_SEQ_TIMEOUT_EN
        timer_d = '0;
`endif
      end
      S_WAIT_DONE: begin
        if (adder_done) begin
          out_sum_d   = adder_sum;
          out_carry_d = adder_carry;
          out_valid_d = 1'b1;
          state_d     = S_RESULT;
        end
`ifdef SERIAL_SEQ_TIMEOUT_EN
        else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          out_sum_d   = '0;
          out_carry_d = 1'b0;
          out_err_d   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = S_RESULT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
`endif
      end
      S_RESULT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_DRAIN;
`ifdef SERIAL_SEQ_TIMEOUT_EN
          out_err_d   = 1'b0;
`endif
        end
      end
      S_DRAIN: begin
        if (!adder_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_carry_q <= 1'b0;
`ifdef SERIAL_SEQ_TIMEOUT_EN
      timer_q     <= '0;
      out_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_carry_q <= out_carry_d;
`ifdef SERIAL_SEQ_TIMEOUT_EN
      timer_q     <= timer_d;
      out_err_q   <= out_err_d;
`endif
    end
  end

`ifdef SERIAL_SEQ_TIMEOUT_EN
  assign out_err = out_err_q;
`else
  assign out_err = 1'b0;
`endif

  assign adder_start = (state_q == S_START);
  assign adder_a     = adder_a_q;
  assign adder_b     = adder_b_q;
  assign out_valid   = out_valid_q;
  assign out_sum     = out_sum_q;
  assign out_carry   = out_carry_q;
  assign pending     = count_q;
  assign busy        = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer: emulates the adder, models expected results as a FIFO of a+b,
// and checks handshakes, stability, ordering, stale-done blocking, reset abandonment and the watchdog.
module tb_serial_add_sequencer;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic         adder_start;
  logic [W-1:0] adder_a, adder_b;
  logic [W-1:0] adder_sum = '0;
  logic         adder_carry = 1'b0;
  logic         adder_done;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_carry, out_err;
  logic [$clog2(D):0] pending;
  logic         busy;

  logic emu_done = 1'b0, force_done = 1'b0;
  assign adder_done = emu_done | force_done;

  always #5 clk = ~clk;

  serial_add_sequencer #(.WIDTH(W), .FIFO_DEPTH(D), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .adder_start(adder_start), .adder_a(adder_a), .adder_b(adder_b), .adder_sum(adder_sum),
    .adder_carry(adder_carry), .adder_done(adder_done), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .out_err(out_err), .pending(pending), .busy(busy)
  );

  typedef struct packed { logic [W-1:0] a; logic [W-1:0] b; } pair_t;
  typedef struct packed { logic [W-1:0] sum; logic carry; logic err; } res_t;

  pair_t iss_q[$];
  res_t  res_q[$];
  res_t  obs_q[$];

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int cyc = 0;
  int last_start_cyc = 0;
  int lat = 3;
  int hold = 2;
  bit no_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string why);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, why);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (adder_start) start_cnt++;
  end

  // Adder emulator: reacts to start, raises done after lat cycles and holds it for hold cycles.
  initial begin
    pair_t p;
    res_t r;
    logic [W:0] full;
    forever begin
      @(posedge clk);
      #1;
      if (rst && adder_start) begin
        last_start_cyc = cyc;
        check("start_done_low", {63'd0, adder_done}, 64'd0);
        if (iss_q.size() == 0) begin
          fail("start_unexpected", "adder_start with no accepted operands");
        end else begin
          p = iss_q.pop_front();
          check("adder_a", {32'd0, adder_a}, {32'd0, p.a});
          check("adder_b", {32'd0, adder_b}, {32'd0, p.b});
          if (!no_done) begin
            full = {1'b0, p.a} + {1'b0, p.b};
            r.sum = full[W-1:0];
            r.carry = full[W];
            r.err = 1'b0;
            res_q.push_back(r);
            repeat (lat) @(posedge clk);
            #1;
            full = {1'b0, adder_a} + {1'b0, adder_b};
            adder_sum = full[W-1:0];
            adder_carry = full[W];
            emu_done = 1'b1;
            repeat (hold) @(posedge clk);
            #1;
            emu_done = 1'b0;
          end else begin
`ifdef SERIAL_SEQ_TIMEOUT_EN
            r.sum = '0;
            r.carry = 1'b0;
            r.err = 1'b1;
            res_q.push_back(r);
`endif
          end
        end
      end
    end
  end

  // Result checker: every handshake against the model; held results must not move.
  initial begin
    bit hold_prev;
    res_t prev, cur, exp;
    hold_prev = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      cur.sum = out_sum;
      cur.carry = out_carry;
      cur.err = out_err;
      if (!rst) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev && out_valid) check("held_result", {31'd0, cur}, {31'd0, prev});
        if (out_valid && out_ready) begin
          if (res_q.size() == 0) begin
            fail("result_unexpected", $sformatf("sum %0h carry %0b err %0b", out_sum, out_carry, out_err));
          end else begin
            exp = res_q.pop_front();
            check("out_sum", {32'd0, cur.sum}, {32'd0, exp.sum});
            check("out_carry", {63'd0, cur.carry}, {63'd0, exp.carry});
            check("out_err", {63'd0, cur.err}, {63'd0, exp.err});
            $display("result sum=%h carry=%0b err=%0b", cur.sum, cur.carry, cur.err);
          end
          obs_q.push_back(cur);
        end
        hold_prev = out_valid && !out_ready;
        prev = cur;
      end
    end
  end

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    pair_t p;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      fail("push_timeout", "in_ready never rose");
    end else begin
      @(posedge clk);
      p.a = a;
      p.b = b;
      iss_q.push_back(p);
      $display("push a=%h b=%h", a, b);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!(!busy && !out_valid && !adder_done && res_q.size() == 0 && iss_q.size() == 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail(name, "sequencer did not return to idle");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    iss_q.delete();
    res_q.delete();
    wait_cycles(2);
    rst = 1'b1;
    wait_cycles(1);
  endtask

  initial begin
    int s0;
    int n;
    bit seen;
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_adder_start", {63'd0, adder_start}, 64'd0);
    check("rst_adder_a", {32'd0, adder_a}, 64'd0);
    check("rst_adder_b", {32'd0, adder_b}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_sum", {32'd0, out_sum}, 64'd0);
    check("rst_out_carry", {63'd0, out_carry}, 64'd0);
    check("rst_out_err", {63'd0, out_err}, 64'd0);
    check("rst_pending", {61'd0, pending}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    wait_cycles(2);

    // Single op
    obs_q.delete();
    s0 = start_cnt;
    push(32'h00000001, 32'h00000001);
    wait_idle("single_idle");
    check("single_starts", 64'(start_cnt - s0), 64'd1);
    check("single_count", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() == 1) check("single_lit", {31'd0, obs_q[0]}, {31'd0, 32'h00000002, 1'b0, 1'b0});

    // Burst with issue held off so the FIFO fills
    obs_q.delete();
    force_done = 1'b1;
    s0 = start_cnt;
    push(32'hFFFFFFFF, 32'h00000001);
    push(32'hDEADBEEF, 32'hCAFEBABE);
    push(32'h12345678, 32'h87654321);
    push(32'h7FFFFFFF, 32'h00000001);
    @(negedge clk);
    check("burst_pending", {61'd0, pending}, 64'd4);
    check("burst_in_ready", {63'd0, in_ready}, 64'd0);
    check("burst_no_start", 64'(start_cnt - s0), 64'd0);
    @(posedge clk);
    #1 force_done = 1'b0;
    wait_idle("burst_idle");
    check("burst_count", 64'(obs_q.size()), 64'd4);
    if (obs_q.size() == 4) begin
      check("burst_lit0", {31'd0, obs_q[0]}, {31'd0, 32'h00000000, 1'b1, 1'b0});
      check("burst_lit1", {31'd0, obs_q[1]}, {31'd0, 32'hA9AC79AD, 1'b1, 1'b0});
      check("burst_lit2", {31'd0, obs_q[2]}, {31'd0, 32'h99999999, 1'b0, 1'b0});
      check("burst_lit3", {31'd0, obs_q[3]}, {31'd0, 32'h80000000, 1'b0, 1'b0});
    end

    // Backpressure with a long done level
    obs_q.delete();
    hold = 40;
    out_ready = 1'b0;
    push(32'h00000010, 32'h00000020);
    push(32'h00000100, 32'h00000200);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) fail("bp_valid", "out_valid never rose");
    s0 = start_cnt;
    wait_cycles(20);
    check("bp_no_start", 64'(start_cnt - s0), 64'd0);
    check("bp_still_valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    wait_idle("bp_idle");
    hold = 2;
    check("bp_count", 64'(obs_q.size()), 64'd2);
    if (obs_q.size() == 2) check("bp_lit1", {31'd0, obs_q[1]}, {31'd0, 32'h00000300, 1'b0, 1'b0});

    // Reset mid-op with two pairs queued
    lat = 20;
    push(32'h00000001, 32'h00000002);
    push(32'h00000003, 32'h00000004);
    push(32'h00000005, 32'h00000006);
    wait_cycles(3);
    @(negedge clk);
    check("mid_pending", {61'd0, pending}, 64'd2);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_pending", {61'd0, pending}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("mid_rst_adder_a", {32'd0, adder_a}, 64'd0);
    check("mid_rst_start", {63'd0, adder_start}, 64'd0);
    iss_q.delete();
    res_q.delete();
    wait_cycles(2);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid || adder_start) seen = 1'b1;
    end
    check("mid_no_result", {63'd0, seen}, 64'd0);
    lat = 3;
    wait_idle("mid_idle");

    // Stale done blocks issue
    obs_q.delete();
    force_done = 1'b1;
    s0 = start_cnt;
    push(32'h0000000A, 32'h00000005);
    wait_cycles(10);
    check("stale_no_start", 64'(start_cnt - s0), 64'd0);
    check("stale_pending", {61'd0, pending}, 64'd1);
    force_done = 1'b0;
    wait_idle("stale_idle");
    check("stale_count", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() == 1) check("stale_lit", {31'd0, obs_q[0]}, {31'd0, 32'h0000000F, 1'b0, 1'b0});

    // Watchdog
    obs_q.delete();
    no_done = 1'b1;
    s0 = start_cnt;
    push(32'h00000055, 32'h000000AA);
    n = 0;
    while (start_cnt == s0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (start_cnt == s0) fail("to_start", "no adder_start");
    n = 0;
    while (!out_valid && n < TO + 40) begin
      @(negedge clk);
      n++;
    end
`ifdef SERIAL_SEQ_TIMEOUT_EN
    check("to_valid", {63'd0, out_valid}, 64'd1);
    check("to_latency", 64'(cyc - last_start_cyc), 64'(TO + 1));
    check("to_err_lit", {63'd0, out_err}, 64'd1);
    no_done = 1'b0;
    wait_idle("to_idle");
`else
    check("to_never_valid", {63'd0, out_valid}, 64'd0);
    check("to_still_busy", {63'd0, busy}, 64'd1);
    no_done = 1'b0;
    do_reset();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
